// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and defaults for the IF-stage fetch controller.
// Fetch state encoding plus default widths and reset address.
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IF_ST_IDLE   = 2'b00,
        IF_ST_BUBBLE = 2'b01,
        IF_ST_RUN    = 2'b10,
        IF_ST_HOLD   = 2'b11
    } if_st_e;

    localparam int unsigned INST_ADDR_W_DEF = 32;
    localparam int unsigned INST_W_DEF      = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buf.sv
// Capture register for the instruction/PC pair presented while IF/ID stalls,
// and the live/held output mux with NOP masking when nothing valid is in IF.
module if_hold_buf
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en_i,
    input  logic              sel_hold_i,
    input  logic              valid_i,
    input  logic [INST_W-1:0] live_inst_i,
    input  logic [ADDR_W-1:0] live_pc_i,
    output logic [INST_W-1:0] if_inst_o,
    output logic [ADDR_W-1:0] if_pc_o
);

    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    always_comb begin
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        if (cap_en_i) begin
            hold_inst_d = live_inst_i;
            hold_pc_d   = live_pc_i;
        end
    end

    // Invalid slots present a NOP at address 0 so ID never sees stale data.
    always_comb begin
        if_inst_o = '0;
        if_pc_o   = '0;
        if (valid_i) begin
            if_inst_o = sel_hold_i ? hold_inst_q : live_inst_i;
            if_pc_o   = sel_hold_i ? hold_pc_q   : live_pc_i;
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// IF-stage controller: owns the PC, sequences the synchronous ROM and re-aligns its data with the PC.
// Outputs depend only on registered state and ROM data; a taken branch costs one bubble.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W   = INST_ADDR_W_DEF,
    parameter int unsigned       INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_pc_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    if_st_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_reg_q, pc_reg_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic              consume;
    logic              take_branch;
    logic              cap_en;
    logic              sel_hold;

    assign consume     = ((state_q == IF_ST_RUN) || (state_q == IF_ST_HOLD)) && !stall_i;
    assign take_branch = consume && branch_flag_i;
    assign next_pc     = take_branch ? (branch_target_i & ALIGN_MASK) : (pc_reg_q + PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IF_ST_IDLE;
            pc_reg_q  <= RESET_PC;
            last_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_reg_q  <= pc_reg_d;
            last_pc_q <= last_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IF_ST_IDLE:   state_d = IF_ST_BUBBLE;
            IF_ST_BUBBLE: state_d = IF_ST_RUN;
            IF_ST_RUN,
            IF_ST_HOLD: begin
                if (stall_i)          state_d = IF_ST_HOLD;
                else if (take_branch) state_d = IF_ST_BUBBLE;
                else                  state_d = IF_ST_RUN;
            end
            default:      state_d = IF_ST_IDLE;
        endcase
    end

    // A redirect leaves last_pc alone: the bubble that follows reloads it from the target.
    always_comb begin
        pc_reg_d  = pc_reg_q;
        last_pc_d = last_pc_q;
        if (state_q == IF_ST_BUBBLE) begin
            pc_reg_d  = next_pc;
            last_pc_d = pc_reg_q;
        end else if (consume) begin
            pc_reg_d = next_pc;
            if (!branch_flag_i) begin
                last_pc_d = pc_reg_q;
            end
        end
    end

    always_comb begin
        rom_ce_o   = (state_q != IF_ST_IDLE);
        if_valid_o = (state_q == IF_ST_RUN) || (state_q == IF_ST_HOLD);
        sel_hold   = (state_q == IF_ST_HOLD);
        cap_en     = (state_q == IF_ST_RUN) && stall_i;
    end

    assign rom_pc_o = pc_reg_q;

    if_hold_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_hold_buf (
        .clk         (clk),
        .rst         (rst),
        .cap_en_i    (cap_en),
        .sel_hold_i  (sel_hold),
        .valid_i     (if_valid_o),
        .live_inst_i (rom_inst_i),
        .live_pc_i   (last_pc_q),
        .if_inst_o   (if_inst_o),
        .if_pc_o     (if_pc_o)
    );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, async reset, PC wrap, and random
// stall/branch traffic checked against a stream-level model of the fetched instruction sequence.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, branch_flag_i;
    logic [31:0] branch_target_i;

    logic        rom_ce_a, if_valid_a;
    logic [31:0] rom_pc_a, rom_inst_a, if_pc_a, if_inst_a;
    logic        rom_ce_b, if_valid_b;
    logic [31:0] rom_pc_b, rom_inst_b, if_pc_b, if_inst_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'hA000_0000 | {2'b00, addr[31:2]};
    endfunction

    always @(posedge clk) if (rom_ce_a) rom_inst_a <= rom_word(rom_pc_a);
    always @(posedge clk) if (rom_ce_b) rom_inst_b <= rom_word(rom_pc_b);

    inst_fetch_ctrl u_dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .rom_ce_o(rom_ce_a), .rom_pc_o(rom_pc_a),
        .rom_inst_i(rom_inst_a), .if_pc_o(if_pc_a), .if_inst_o(if_inst_a), .if_valid_o(if_valid_a)
    );

    inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .rom_ce_o(rom_ce_b), .rom_pc_o(rom_pc_b),
        .rom_inst_i(rom_inst_b), .if_pc_o(if_pc_b), .if_inst_o(if_inst_b), .if_valid_o(if_valid_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model: gap = invalid cycles before the next valid instruction, m_pc = its address.
    int          m_gap;
    logic [31:0] m_pc;

    task automatic model_reset();
        m_gap = 2;
        m_pc  = 32'h0;
    endtask

    task automatic model_update();
        if (m_gap > 0) m_gap--;
        else if (!stall_i) begin
            if (branch_flag_i) begin
                m_pc  = branch_target_i & ~32'h3;
                m_gap = 1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        logic v;
        v = (m_gap == 0);
        chk("rand_valid", if_valid_a, v);
        chk("rand_pc", if_pc_a, v ? m_pc : 32'h0);
        chk("rand_inst", if_inst_a, v ? rom_word(m_pc) : 32'h0);
        chk("rand_ce", rom_ce_a, (m_gap != 2));
        chk("rand_rom_pc", rom_pc_a, (m_gap > 0) ? m_pc : m_pc + 32'd4);
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] t);
        stall_i         = s;
        branch_flag_i   = b;
        branch_target_i = t;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        ece;
        logic [31:0] erpc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic v,
                                input logic [31:0] pc, input logic [31:0] inst, input logic ce,
                                input logic [31:0] rpc);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.ev = v; r.epc = pc; r.einst = inst; r.ece = ce; r.erpc = rpc;
        return r;
    endfunction

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].tgt);
            #1;
            chk($sformatf("row%0d_valid", i), if_valid_a, tbl[i].ev);
            chk($sformatf("row%0d_pc", i), if_pc_a, tbl[i].epc);
            chk($sformatf("row%0d_inst", i), if_inst_a, tbl[i].einst);
            chk($sformatf("row%0d_ce", i), rom_ce_a, tbl[i].ece);
            chk($sformatf("row%0d_rom_pc", i), rom_pc_a, tbl[i].erpc);
            tick();
        end
    endtask

    localparam logic [31:0] A = 32'hA000_0000;

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);

        // Reset/startup, 3-cycle stall, taken branch, branch held under stall with misaligned target.
        tbl[0]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  1, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,  1, 32'h0,  A | 0,  1, 32'h4);
        tbl[3]  = mk(0, 0, 32'h0,  1, 32'h4,  A | 1,  1, 32'h8);
        tbl[4]  = mk(1, 0, 32'h0,  1, 32'h8,  A | 2,  1, 32'hC);
        tbl[5]  = mk(1, 0, 32'h0,  1, 32'h8,  A | 2,  1, 32'hC);
        tbl[6]  = mk(1, 0, 32'h0,  1, 32'h8,  A | 2,  1, 32'hC);
        tbl[7]  = mk(0, 0, 32'h0,  1, 32'h8,  A | 2,  1, 32'hC);
        tbl[8]  = mk(0, 0, 32'h0,  1, 32'hC,  A | 3,  1, 32'h10);
        tbl[9]  = mk(0, 1, 32'h40, 1, 32'h10, A | 4,  1, 32'h14);
        tbl[10] = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  1, 32'h40);
        tbl[11] = mk(0, 0, 32'h0,  1, 32'h40, A | 16, 1, 32'h44);
        tbl[12] = mk(1, 1, 32'h43, 1, 32'h44, A | 17, 1, 32'h48);
        tbl[13] = mk(1, 1, 32'h43, 1, 32'h44, A | 17, 1, 32'h48);
        tbl[14] = mk(0, 1, 32'h43, 1, 32'h44, A | 17, 1, 32'h48);
        tbl[15] = mk(0, 0, 32'h0,  0, 32'h0,  32'h0,  1, 32'h40);
        tbl[16] = mk(0, 0, 32'h0,  1, 32'h40, A | 16, 1, 32'h44);
        tbl[17] = mk(0, 0, 32'h0,  1, 32'h44, A | 17, 1, 32'h48);

        do_reset();
        apply_rows(0, 17);

        // Async reset pulse mid-HOLD, then the startup sequence must repeat exactly.
        drive(1'b1, 1'b0, 32'h0);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", if_valid_a, 1'b0);
        chk("arst_pc", if_pc_a, 32'h0);
        chk("arst_inst", if_inst_a, 32'h0);
        chk("arst_ce", rom_ce_a, 1'b0);
        chk("arst_rom_pc", rom_pc_a, 32'h0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        apply_rows(0, 4);

        // PC wrap from RESET_PC = FFFFFFF8.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [31:0] wpc;
            drive(1'b0, 1'b0, 32'h0);
            #1;
            wpc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
            chk($sformatf("wrap%0d_valid", k), if_valid_b, (k >= 2));
            chk($sformatf("wrap%0d_pc", k), if_pc_b, (k >= 2) ? wpc : 32'h0);
            chk($sformatf("wrap%0d_inst", k), if_inst_b, (k >= 2) ? rom_word(wpc) : 32'h0);
            chk($sformatf("wrap%0d_ce", k), rom_ce_b, (k != 0));
            chk($sformatf("wrap%0d_rom_pc", k), rom_pc_b,
                (k < 2) ? 32'hFFFF_FFF8 : wpc + 32'd4);
            tick();
        end

        // Random stall/branch traffic against the stream model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom);
            #1;
            check_model();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
